spram_arbiter: RTL

SPRAM_ARBITER -- requirements
Module: spram_arbiter

---
 rtl/spram_arb_pkg.sv | 15 +
 rtl/spram_arbiter_grant.sv | 55 +++++
 rtl/spram_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/spram_arb_pkg.sv
// Shared definitions for the single-port RAM arbiter.
//   port_e     : requester identity carried down the read tag pipeline
//                (PORT_A = video scan, PORT_B = CPU)
//   STARVE_MAX : number of consecutive A wins over a waiting B after which
//                B is forced through (only used with SPRAM_ARB_FAIR_EN)
package spram_arb_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    localparam logic [1:0] STARVE_MAX = 2'd3;

endpackage

// File: rtl/spram_arbiter_grant.sv
// Grant decision for the two-port RAM arbiter.
// Purely combinational grant from the current requests; at most one grant
// is ever high.
//
// Optional feature macro: SPRAM_ARB_FAIR_EN
//   undefined : fixed priority, A always beats B, no state at all.
//   defined   : a 2-bit starve counter lets B through after A has won
//               STARVE_MAX times in a row while B was waiting.
//
// Ports:
//   clock, reset_n   : clock and async active-low reset (fair build only)
//   a_req, b_req     : pending requests
//   grant_a, grant_b : the request accepted at the coming rising edge
module arb_grant
    import spram_arb_pkg::*;
(
`ifdef SPRAM_ARB_FAIR_EN
    input  logic clock,
    input  logic reset_n,
`endif
    input  logic a_req,
    input  logic b_req,
    output logic grant_a,
    output logic grant_b
);

`ifdef SPRAM_ARB_FAIR_EN
    logic [1:0] starve_cnt;
    logic       b_first;

    // B overrides A only once it has watched A win STARVE_MAX times.
    assign b_first = b_req && (starve_cnt == STARVE_MAX);

    always_comb begin
        grant_a = a_req && !b_first;
        grant_b = b_req && !grant_a;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 2'd0;
        end else if (!b_req || grant_b) begin
            starve_cnt <= 2'd0;
        end else if (grant_a && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 2'd1;
        end
    end
`else
    always_comb begin
        grant_a = a_req;
        grant_b = b_req && !a_req;
    end
`endif

endmodule

// File: rtl/spram_arbiter.sv
// Two-requester front end for a single-port synchronous RAM (1-cycle read
// latency). Port A is the video scan-out, port B is the CPU.
//
// Timing, for a request accepted at edge k:
//   k   : RAM address/data/wren registered, ack raised for one cycle
//   k+1 : RAM samples the access; read data appears on ram_q
//   k+2 : ram_q captured into the owner's rdata, rvalid raised for one cycle
// A read tag (valid + owner) follows each access down a two-stage pipeline
// so overlapping A/B reads return to the right port in acceptance order.
//
// Optional feature macro: SPRAM_ARB_FAIR_EN (starve counter in arb_grant).
//
// Ports:
//   clock, reset_n                  : clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata       : port A request (held until ack)
//   b_req/b_we/b_addr/b_wdata       : port B request (held until ack)
//   a_ack, b_ack                    : one-cycle accept pulse
//   a_rdata/a_rvalid, b_rdata/b_rvalid : read return, rdata held between reads
//   ram_address/ram_data/ram_wren   : to the RAM
//   ram_q                           : from the RAM
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int widthad_a  = 15,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [widthad_a-1:0]  a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [widthad_a-1:0]  b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,

    output logic [widthad_a-1:0]  ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    logic  grant_a;
    logic  grant_b;
    logic  rd_accept;
    port_e rd_port;

    logic  vld_p0;
    port_e port_p0;
    logic  vld_p1;
    port_e port_p1;

    arb_grant u_grant (
`ifdef SPRAM_ARB_FAIR_EN
        .clock   (clock),
        .reset_n (reset_n),
`endif
        .a_req   (a_req),
        .b_req   (b_req),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    always_comb begin
        rd_accept = (grant_a && !a_we) || (grant_b && !b_we);
        rd_port   = grant_a ? PORT_A : PORT_B;
    end

    // Stage p0: accept edge -- drive the RAM, ack the winner, tag a read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            vld_p0      <= 1'b0;
            port_p0     <= PORT_A;
        end else begin
            a_ack    <= grant_a;
            b_ack    <= grant_b;
            ram_wren <= 1'b0;
            if (grant_a) begin
                ram_address <= a_addr;
                ram_data    <= a_wdata;
                ram_wren    <= a_we;
            end else if (grant_b) begin
                ram_address <= b_addr;
                ram_data    <= b_wdata;
                ram_wren    <= b_we;
            end
            vld_p0  <= rd_accept;
            port_p0 <= rd_port;
        end
    end

    // Stage p1: RAM is performing the read; ram_q becomes valid after this edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            port_p1 <= PORT_A;
        end else begin
            vld_p1  <= vld_p0;
            port_p1 <= port_p0;
        end
    end

    // Stage p2: capture ram_q into the owning port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata  <= '0;
            b_rdata  <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            if (vld_p1) begin
                if (port_p1 == PORT_A) begin
                    a_rdata  <= ram_q;
                    a_rvalid <= 1'b1;
                end else begin
                    b_rdata  <= ram_q;
                    b_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule
